// File: rtl/axis_master_mlp_out.sv
`default_nettype none
// ============================================================================
//  Module   : axis_master_mlp_out
//  Brief    : AXI4-Stream master returning MLP result words to the host.
//             Result words are buffered in a show-ahead FIFO and sent as
//             fixed-length packets, with TLAST on the final beat of each.
//  Revision : 1.0 - initial release
// ============================================================================
module axis_master_mlp_out #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int C_FIFO_DEPTH         = 8,
  parameter int C_FRAME_LEN          = 10
) (
  input  logic                                M_AXIS_ACLK,
  input  logic                                M_AXIS_ARESET,
  // MLP core side
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     pi_mlp_data,
  input  logic                                pi_mlp_data_valid,
  output logic                                po_mlp_ready,
  output logic                                po_overflow,
  output logic                                po_frame_done,
  // AXI4-Stream master
  output logic                                M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [(C_M_AXIS_TDATA_WIDTH/8)-1:0] M_AXIS_TSTRB,
  output logic                                M_AXIS_TLAST,
  input  logic                                M_AXIS_TREADY
);

  // Pointer width, occupancy width (must hold C_FIFO_DEPTH itself) and
  // beat counter width (at least one bit even for single-beat packets).
  localparam int C_AW = $clog2(C_FIFO_DEPTH);
  localparam int C_CW = C_AW + 1;
  localparam int C_BW = (C_FRAME_LEN > 1) ? $clog2(C_FRAME_LEN) : 1;

  localparam logic [C_CW-1:0] C_DEPTH_CNT = C_CW'(C_FIFO_DEPTH);
  localparam logic [C_BW-1:0] C_LAST_BEAT = C_BW'(C_FRAME_LEN - 1);
  localparam int              C_STRB_W    = C_M_AXIS_TDATA_WIDTH / 8;

  // Two-state stream FSM: IDLE while the FIFO is empty, STREAM otherwise.
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t state_q, state_d;

  // FIFO storage is deliberately left without reset; the read path is gated
  // by TVALID so stale contents never reach the stream.
  logic [C_M_AXIS_TDATA_WIDTH-1:0] mem_q [C_FIFO_DEPTH];

  logic [C_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [C_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [C_CW-1:0] count_q,  count_d;
  logic [C_BW-1:0] beat_q,   beat_d;
  logic            overflow_q, overflow_d;
  logic            frame_done_q, frame_done_d;

  logic w_push;
  logic w_pop;
  logic w_drop;
  logic w_tvalid;
  logic w_tlast;

  // --------------------------------------------------------------------------
  // Handshake decode. Ready looks only at registered occupancy, so a word
  // offered while full is dropped even if a pop happens in the same cycle.
  // --------------------------------------------------------------------------
  assign po_mlp_ready = (count_q != C_DEPTH_CNT);
  assign w_push       = pi_mlp_data_valid &&  po_mlp_ready;
  assign w_drop       = pi_mlp_data_valid && !po_mlp_ready;

  // TVALID comes straight from the state register and never from TREADY.
  assign w_tvalid = (state_q == ST_STREAM);
  assign w_tlast  = w_tvalid && (beat_q == C_LAST_BEAT);
  assign w_pop    = w_tvalid && M_AXIS_TREADY;

  assign M_AXIS_TVALID = w_tvalid;
  assign M_AXIS_TLAST  = w_tlast;
  assign M_AXIS_TDATA  = w_tvalid ? mem_q[rd_ptr_q] : '0;
  assign po_overflow   = overflow_q;
  assign po_frame_done = frame_done_q;

  // Every byte of every beat is a data byte.
  for (genvar b = 0; b < C_STRB_W; b++) begin : g_strb
    assign M_AXIS_TSTRB[b] = 1'b1;
  end

  // --------------------------------------------------------------------------
  // Datapath next state: pointers, occupancy, beat position and flags.
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    beat_d       = beat_q;
    overflow_d   = overflow_q;
    frame_done_d = 1'b0;

    // Power-of-two depth makes the natural wrap of the pointer the modulo.
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + C_AW'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + C_AW'(1);
    end

    unique case ({w_push, w_pop})
      2'b10:   count_d = count_q + C_CW'(1);
      2'b01:   count_d = count_q - C_CW'(1);
      default: count_d = count_q;
    endcase

    // The beat counter only follows accepted beats, so a packet may be
    // interrupted by empty gaps without losing its position.
    if (w_pop) begin
      if (w_tlast) begin
        beat_d       = '0;
        frame_done_d = 1'b1;
      end else begin
        beat_d = beat_q + C_BW'(1);
      end
    end

    if (w_drop) begin
      overflow_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Stream FSM next state. Leaving STREAM needs the last word popped with no
  // refill in the same cycle; otherwise TVALID stays up without a bubble.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (count_d != '0) begin
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (w_pop && !w_push && (count_q == C_CW'(1))) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with asynchronous reset; a mid-packet reset drops TVALID
  // immediately and restarts the next packet at beat 0.
  always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
    if (M_AXIS_ARESET) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      beat_q       <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      beat_q       <= beat_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  // FIFO write port; only accepted words are stored.
  always_ff @(posedge M_AXIS_ACLK) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= pi_mlp_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_master_mlp_out.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_master_mlp_out
//  Brief    : Self-checking bench for axis_master_mlp_out. A 4-beat-packet
//             instance runs a vector table; a 10-beat-packet instance runs
//             the multi-cycle sequences against a beat scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axis_master_mlp_out;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- instance A: C_FRAME_LEN = 4 ----------------
  logic [W-1:0] a_data   = '0;
  logic         a_valid  = 1'b0;
  logic         a_tready = 1'b0;
  logic         a_ready, a_ovf, a_fd, a_tvalid, a_tlast;
  logic [W-1:0] a_tdata;
  logic [3:0]   a_tstrb;

  axis_master_mlp_out #(
    .C_M_AXIS_TDATA_WIDTH(W), .C_FIFO_DEPTH(8), .C_FRAME_LEN(4)
  ) u_dut4 (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESET(rst),
    .pi_mlp_data(a_data), .pi_mlp_data_valid(a_valid),
    .po_mlp_ready(a_ready), .po_overflow(a_ovf), .po_frame_done(a_fd),
    .M_AXIS_TVALID(a_tvalid), .M_AXIS_TDATA(a_tdata), .M_AXIS_TSTRB(a_tstrb),
    .M_AXIS_TLAST(a_tlast), .M_AXIS_TREADY(a_tready)
  );

  // ---------------- instance B: C_FRAME_LEN = 10 ----------------
  logic [W-1:0] b_data   = '0;
  logic         b_valid  = 1'b0;
  logic         b_tready = 1'b0;
  logic         b_ready, b_ovf, b_fd, b_tvalid, b_tlast;
  logic [W-1:0] b_tdata;
  logic [3:0]   b_tstrb;

  axis_master_mlp_out #(
    .C_M_AXIS_TDATA_WIDTH(W), .C_FIFO_DEPTH(8), .C_FRAME_LEN(10)
  ) u_dut (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESET(rst),
    .pi_mlp_data(b_data), .pi_mlp_data_valid(b_valid),
    .po_mlp_ready(b_ready), .po_overflow(b_ovf), .po_frame_done(b_fd),
    .M_AXIS_TVALID(b_tvalid), .M_AXIS_TDATA(b_tdata), .M_AXIS_TSTRB(b_tstrb),
    .M_AXIS_TLAST(b_tlast), .M_AXIS_TREADY(b_tready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard for instance B ----------------
  logic [W-1:0] exp_q[$];
  int   beat_mod = 0;
  int   b_beats  = 0;
  int   b_fd_cnt = 0;
  logic fd_exp   = 1'b0;

  // At the falling edge, a visible TVALID&&TREADY is the beat the next edge takes.
  always @(negedge clk) begin
    if (!rst) begin
      chk("frame_done", 32'(b_fd), 32'(fd_exp));
      if (b_fd) b_fd_cnt++;
      fd_exp = 1'b0;
      if (b_tvalid && b_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_beat actual=0x%0h required=none", b_tdata);
        end else begin
          chk("beat_data", b_tdata, exp_q.pop_front());
        end
        chk("beat_tlast", 32'(b_tlast), 32'(beat_mod == 9));
        fd_exp   = (beat_mod == 9);
        beat_mod = (beat_mod == 9) ? 0 : beat_mod + 1;
        b_beats++;
      end
    end
  end

  // ---------------- vector table for instance A ----------------
  typedef struct {
    logic         vld;
    logic [W-1:0] data;
    logic         tready;
    logic         e_tvalid;
    logic [W-1:0] e_tdata;
    logic         e_tlast;
    logic         e_fd;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_beats;
    int base_fd;
    int cyc;
    int n;

    tbl[0] = '{1'b1, 32'd3,  1'b1, 1'b1, 32'd3,  1'b0, 1'b0};
    tbl[1] = '{1'b1, 32'd14, 1'b1, 1'b1, 32'd14, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 32'd25, 1'b1, 1'b1, 32'd25, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 32'd36, 1'b1, 1'b1, 32'd36, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 32'd0,  1'b1, 1'b0, 32'd0,  1'b0, 1'b1};
    tbl[5] = '{1'b0, 32'd0,  1'b1, 1'b0, 32'd0,  1'b0, 1'b0};

    // ---- reset values ----
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_tvalid", 32'(a_tvalid), 32'd0);
    chk("rst_a_ready",  32'(a_ready),  32'd1);
    chk("rst_b_tvalid", 32'(b_tvalid), 32'd0);
    chk("rst_b_tlast",  32'(b_tlast),  32'd0);
    chk("rst_b_tdata",  b_tdata,       32'd0);
    chk("rst_b_ready",  32'(b_ready),  32'd1);
    chk("rst_b_ovf",    32'(b_ovf),    32'd0);
    chk("rst_b_fd",     32'(b_fd),     32'd0);
    rst = 1'b0;
    step();

    // ---- basic 4-beat packet from the table ----
    for (int i = 0; i < 6; i++) begin
      a_valid  = tbl[i].vld;
      a_data   = tbl[i].data;
      a_tready = tbl[i].tready;
      step();
      chk($sformatf("tbl%0d_tvalid", i), 32'(a_tvalid), 32'(tbl[i].e_tvalid));
      chk($sformatf("tbl%0d_tdata", i),  a_tdata,       tbl[i].e_tdata);
      chk($sformatf("tbl%0d_tlast", i),  32'(a_tlast),  32'(tbl[i].e_tlast));
      chk($sformatf("tbl%0d_fd", i),     32'(a_fd),     32'(tbl[i].e_fd));
      chk($sformatf("tbl%0d_tstrb", i),  32'(a_tstrb),  32'hF);
      chk($sformatf("tbl%0d_ready", i),  32'(a_ready),  32'd1);
    end
    a_valid = 1'b0;

    // ---- random TREADY: 3 packets of 10 words ----
    base_beats = b_beats;
    base_fd    = b_fd_cnt;
    n   = 0;
    cyc = 0;
    while ((n < 30 || exp_q.size() != 0) && cyc < 2000) begin
      b_tready = 1'($urandom_range(0, 1));
      if (n < 30 && b_ready) begin
        b_valid = 1'b1;
        b_data  = 32'(3 + 11 * n);
        exp_q.push_back(b_data);
        n++;
      end else begin
        b_valid = 1'b0;
      end
      step();
      cyc++;
    end
    b_valid  = 1'b0;
    b_tready = 1'b0;
    step();
    step();
    chk("rand_drained", 32'(cyc < 2000), 32'd1);
    chk("rand_beats",   32'(b_beats - base_beats), 32'd30);
    chk("rand_fd_cnt",  32'(b_fd_cnt - base_fd),   32'd3);
    chk("rand_ovf",     32'(b_ovf), 32'd0);

    // ---- continuous push/pop through pointer wrap ----
    base_beats = b_beats;
    b_tready   = 1'b1;
    for (int k = 0; k < 50; k++) begin
      b_valid = 1'b1;
      b_data  = 32'h1000 + 32'(k);
      exp_q.push_back(b_data);
      step();
      chk("wrap_tvalid", 32'(b_tvalid), 32'd1);
      chk("wrap_tdata",  b_tdata, 32'h1000 + 32'(k));
      chk("wrap_ready",  32'(b_ready), 32'd1);
    end
    b_valid = 1'b0;
    step();
    chk("wrap_tvalid_drop", 32'(b_tvalid), 32'd0);
    step();
    chk("wrap_beats", 32'(b_beats - base_beats), 32'd50);
    chk("wrap_ovf",   32'(b_ovf), 32'd0);

    // ---- backpressure, full FIFO and overflow ----
    base_beats = b_beats;
    b_tready   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      b_valid = 1'b1;
      b_data  = 32'h2000 + 32'(k);
      exp_q.push_back(b_data);
      step();
      chk("bp_fill_tvalid", 32'(b_tvalid), 32'd1);
      chk("bp_fill_tdata",  b_tdata, 32'h2000);
      chk("bp_fill_ready",  32'(b_ready), 32'(k < 7));
    end
    b_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("bp_stall_tvalid", 32'(b_tvalid), 32'd1);
      chk("bp_stall_tdata",  b_tdata, 32'h2000);
      chk("bp_stall_ready",  32'(b_ready), 32'd0);
    end
    b_valid = 1'b1;
    b_data  = 32'h2999;
    step();
    b_valid = 1'b0;
    chk("bp_ovf_set", 32'(b_ovf), 32'd1);
    b_tready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      step();
      cyc++;
    end
    step();
    step();
    chk("bp_drained", 32'(cyc < 50), 32'd1);
    chk("bp_beats",   32'(b_beats - base_beats), 32'd8);
    chk("bp_ovf_sticky", 32'(b_ovf), 32'd1);

    // Finish the open packet (beat 8 of 10) so the next one starts at beat 0.
    base_fd = b_fd_cnt;
    for (int k = 0; k < 2; k++) begin
      b_valid = 1'b1;
      b_data  = 32'h2A00 + 32'(k);
      exp_q.push_back(b_data);
      step();
    end
    b_valid = 1'b0;
    step();
    step();
    chk("fill_fd_cnt", 32'(b_fd_cnt - base_fd), 32'd1);

    // ---- reset mid-packet: 5 beats sent, 3 queued ----
    b_tready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      b_valid = 1'b1;
      b_data  = 32'h3000 + 32'(k);
      exp_q.push_back(b_data);
      step();
    end
    b_valid    = 1'b0;
    b_tready   = 1'b1;
    base_beats = b_beats;
    cyc = 0;
    while ((b_beats - base_beats) < 5 && cyc < 50) begin
      step();
      cyc++;
    end
    chk("mid_tvalid_before", 32'(b_tvalid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", 32'(b_tvalid), 32'd0);
    chk("mid_rst_ovf",    32'(b_ovf),    32'd0);
    chk("mid_rst_ready",  32'(b_ready),  32'd1);
    chk("mid_rst_tlast",  32'(b_tlast),  32'd0);
    exp_q.delete();
    beat_mod = 0;
    fd_exp   = 1'b0;
    step();
    rst = 1'b0;

    base_beats = b_beats;
    base_fd    = b_fd_cnt;
    for (int k = 0; k < 10; k++) begin
      b_valid = 1'b1;
      b_data  = 32'h4000 + 32'(k);
      exp_q.push_back(b_data);
      step();
    end
    b_valid = 1'b0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      step();
      cyc++;
    end
    step();
    step();
    chk("post_rst_beats",  32'(b_beats - base_beats), 32'd10);
    chk("post_rst_fd_cnt", 32'(b_fd_cnt - base_fd),   32'd1);
    chk("post_rst_tvalid", 32'(b_tvalid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
